nes_poll_scheduler: RTL and testbench
=====================================

// Module: nes_poll_scheduler
// PURPOSE
//  Sequences the nes_controller serial reader: issues periodic read requests, waits for
//  the result with a watchdog, and publishes a held button state plus per-bit press/release
//  event pulses. Sits between nes_controller (i_read_buttons/o_valid/o_buttons) and game logic.
//  Replaces ad-hoc free-running read counters in top levels.
// PARAMETERS
//  POLL_PERIOD     416667  cycles between periodic polls (60 Hz at 25 MHz); must be >= 2
//  TIMEOUT_CYCLES  16384   max cycles in WAIT for i_valid before declaring timeout; >= 2
// PORTS
//  clk              in   1  system clock
//  i_rst_n          in   1  asynchronous active-low reset
//  i_enable         in   1  1 = periodic polling runs; 0 = period counter held at 0
//  i_poll_now       in   1  one-shot manual poll request (honoured regardless of i_enable)
//  o_read_buttons   out  1  one-cycle strobe to nes_controller i_read_buttons
//  i_valid          in   1  nes_controller o_valid (one-cycle result strobe)
//  i_buttons        in   8  nes_controller o_buttons, sampled only when i_valid in WAIT
//  o_buttons        out  8  held button state, 1 = pressed
//  o_pressed        out  8  one-cycle pulse, bits that went 0->1 on this update
//  o_released       out  8  one-cycle pulse, bits that went 1->0 on this update
//  o_update         out  1  one-cycle pulse, o_buttons/o_pressed/o_released just updated
//  o_timeout        out  1  one-cycle pulse, watchdog expired in WAIT
//  o_overrun        out  1  one-cycle pulse, request dropped (pending slot already full)
//  o_busy           out  1  1 when state != IDLE
// BEHAVIOUR
//  Reset (i_rst_n=0, async): state IDLE, all counters 0, pending 0, every output 0.
//  Period counter: width $clog2(POLL_PERIOD); counts 0..POLL_PERIOD-1 and wraps while
//   i_enable=1; tick = enable & (count==POLL_PERIOD-1); forced to 0 while i_enable=0.
//  req = tick | i_poll_now (same-cycle tick+poll_now = one request).
//  FSM, state registered, outputs registered/decoded from state:
//   IDLE: if req|pending -> REQ; pending cleared. else stay.
//   REQ : o_read_buttons=1 for exactly this cycle; timeout counter cleared; -> WAIT.
//   WAIT: timeout counter increments each cycle.
//         i_valid=1 -> o_buttons<=i_buttons; o_pressed<=i_buttons&~o_buttons;
//           o_released<=~i_buttons&o_buttons; o_update<=1; -> IDLE.
//         else count==TIMEOUT_CYCLES-1 -> o_timeout<=1; o_buttons<=0;
//           o_released<=old o_buttons; o_pressed<=0; o_update<=1; -> IDLE.
//         i_valid and expiry in same cycle: valid wins, no timeout.
//  Latency: req in IDLE at cycle N -> o_read_buttons high at N+1; i_valid at cycle M
//   -> o_buttons/o_update at M+1 and IDLE at M+1; a pending request issues read at M+2.
//  req while state!=IDLE (or IDLE with pending): pending<=1; if pending already 1 ->
//   o_overrun pulse, request dropped (one-deep queue, never more than one queued).
//  i_valid outside WAIT ignored (no output change). o_pressed/o_released/o_update/
//   o_timeout/o_overrun default 0 every cycle not listed above.
//  Unchanged buttons on valid: o_update=1, o_pressed=o_released=0.
//  Deasserting i_enable mid-WAIT does not abort the transaction.
//  Async reset mid-transaction returns to IDLE immediately; no strobe emitted after.
// TESTING  (POLL_PERIOD=20, TIMEOUT_CYCLES=10 unless noted)
//  1 Reset release, i_enable=1 -> first o_read_buttons 20 cycles later, then every 20 cycles.
//  2 WAIT, i_valid with i_buttons=8'h81 after 8'h01 held -> o_buttons=8'h81, o_pressed=8'h80,
//    o_released=0, o_update=1 one cycle; next valid 8'h80 -> o_released=8'h01.
//  3 No i_valid after read -> o_timeout pulse 10 cycles after REQ, o_buttons=0,
//    o_released=prior state; i_valid on expiry cycle -> normal update, no timeout.
//  4 i_poll_now twice during WAIT -> one pending read issued 1 cycle after return
//    to IDLE (M+2), second poll_now gives o_overrun=1 for one cycle.
//  5 i_enable=0 -> no periodic reads; i_poll_now still produces read at next cycle.
//  6 Assert i_rst_n=0 during WAIT -> all outputs 0 asynchronously, state IDLE, pending 0.

Source files
------------

// File: rtl/nes_poll_scheduler_if.sv
// nes_poll_scheduler_if: control, controller-handshake and button-result signals of the poll scheduler
//   i_enable        periodic polling enable
//   i_poll_now      one-shot manual poll request
//   o_read_buttons  read strobe towards nes_controller
//   i_valid         result strobe from nes_controller
//   i_buttons       raw buttons from nes_controller
//   o_buttons       held button state
//   o_pressed       0->1 edges on the latest update
//   o_released      1->0 edges on the latest update
//   o_update        result just published
//   o_timeout       watchdog expired
//   o_overrun       request dropped, queue full
//   o_busy          transaction in progress
interface nes_poll_scheduler_if;
    logic       i_enable;
    logic       i_poll_now;
    logic       o_read_buttons;
    logic       i_valid;
    logic [7:0] i_buttons;
    logic [7:0] o_buttons;
    logic [7:0] o_pressed;
    logic [7:0] o_released;
    logic       o_update;
    logic       o_timeout;
    logic       o_overrun;
    logic       o_busy;
    modport master (
        input  i_enable, i_poll_now, i_valid, i_buttons,
        output o_read_buttons, o_buttons, o_pressed, o_released,
               o_update, o_timeout, o_overrun, o_busy
    );
    modport slave (
        output i_enable, i_poll_now, i_valid, i_buttons,
        input  o_read_buttons, o_buttons, o_pressed, o_released,
               o_update, o_timeout, o_overrun, o_busy
    );
endinterface

// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: issues periodic/manual nes_controller reads, watchdogs the reply, publishes buttons and edge pulses
//   clk      system clock
//   i_rst_n  asynchronous active-low reset
//   bus      nes_poll_scheduler_if.master (controls, controller handshake, button results)
module nes_poll_scheduler #(
    parameter int POLL_PERIOD    = 416667,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    nes_poll_scheduler_if.master  bus
);
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t        state, state_n;
    logic          pending, pending_n, overrun_n;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    btn, prs, rel;
    logic          upd, tmo, ovr;
    logic          tick, req, got, expire;
    assign tick   = bus.i_enable && pcnt == PW'(POLL_PERIOD - 1);
    assign req    = tick | bus.i_poll_now;
    assign got    = state == WAIT && bus.i_valid;
    // valid on the expiry cycle wins over the watchdog
    assign expire = state == WAIT && !bus.i_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_comb begin
        state_n   = state;
        pending_n = pending;
        overrun_n = 1'b0;
        case (state)
            IDLE: begin
                // a queued request and a fresh one collapse into this single read
                if (req | pending) state_n = REQ;
                pending_n = 1'b0;
                overrun_n = req & pending;
            end
            REQ: begin
                state_n = WAIT;
                if (req) begin
                    pending_n = 1'b1;
                    overrun_n = pending;
                end
            end
            default: begin
                if (got | expire) state_n = IDLE;
                if (req) begin
                    pending_n = 1'b1;
                    overrun_n = pending;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            pcnt    <= '0;
            tcnt    <= '0;
            btn     <= '0;
            prs     <= '0;
            rel     <= '0;
            upd     <= 1'b0;
            tmo     <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            ovr     <= overrun_n;
            pcnt    <= bus.i_enable ? (tick ? '0 : pcnt + 1'b1) : '0;
            tcnt    <= state == REQ ? '0 : state == WAIT ? tcnt + 1'b1 : tcnt;
            prs     <= '0;
            rel     <= '0;
            upd     <= 1'b0;
            tmo     <= 1'b0;
            if (got) begin
                btn <= bus.i_buttons;
                prs <= bus.i_buttons & ~btn;
                rel <= ~bus.i_buttons & btn;
                upd <= 1'b1;
            end else if (expire) begin
                // a lost controller reads as everything released
                btn <= '0;
                rel <= btn;
                upd <= 1'b1;
                tmo <= 1'b1;
            end
        end
    end
    assign bus.o_read_buttons = state == REQ;
    assign bus.o_busy         = state != IDLE;
    assign bus.o_buttons      = btn;
    assign bus.o_pressed      = prs;
    assign bus.o_released     = rel;
    assign bus.o_update       = upd;
    assign bus.o_timeout      = tmo;
    assign bus.o_overrun      = ovr;
endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb_nes_poll_scheduler: randomized and directed checks of nes_poll_scheduler against a transaction-level model
module tb_nes_poll_scheduler;
    localparam int P = 20;
    localparam int T = 10;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    nes_poll_scheduler_if bus();
    nes_poll_scheduler #(.POLL_PERIOD(P), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );
    int total = 0;
    int bad = 0;
    // model: age = -2 idle, -1 read strobe cycle, >=0 cycles already spent waiting
    int pc, age;
    int q[$];
    logic [7:0] m_btn, m_prs, m_rel;
    bit m_upd, m_to, m_ov, m_rd, m_busy;
    int vmode = 0;
    int ppoll = 0;
    bit entog = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        pc = 0;
        age = -2;
        q.delete();
        {m_btn, m_prs, m_rel} = '0;
        {m_upd, m_to, m_ov, m_rd, m_busy} = '0;
    endtask
    task automatic model_step();
        bit req;
        req = (bus.i_enable && pc == P - 1) || bus.i_poll_now;
        pc = bus.i_enable ? (pc + 1) % P : 0;
        {m_prs, m_rel} = '0;
        {m_upd, m_to, m_ov} = '0;
        if (age == -2) begin
            if (req || q.size() > 0) begin
                m_ov = req && q.size() > 0;
                q.delete();
                age = -1;
            end
        end else begin
            if (req) begin
                if (q.size() > 0) m_ov = 1;
                else q.push_back(1);
            end
            if (age == -1) age = 0;
            else if (bus.i_valid) begin
                m_prs = bus.i_buttons & ~m_btn;
                m_rel = ~bus.i_buttons & m_btn;
                m_btn = bus.i_buttons;
                m_upd = 1;
                age = -2;
            end else if (age == T - 1) begin
                m_to = 1;
                m_rel = m_btn;
                m_btn = 0;
                m_upd = 1;
                age = -2;
            end else age++;
        end
        m_rd = age == -1;
        m_busy = age != -2;
    endtask
    task automatic compare();
        check("rd", bus.o_read_buttons, m_rd);
        check("busy", bus.o_busy, m_busy);
        check("btn", bus.o_buttons, m_btn);
        check("prs", bus.o_pressed, m_prs);
        check("rel", bus.o_released, m_rel);
        check("upd", bus.o_update, m_upd);
        check("tmo", bus.o_timeout, m_to);
        check("ovr", bus.o_overrun, m_ov);
    endtask
    task automatic drive();
        bus.i_poll_now = ($urandom % 100) < ppoll;
        bus.i_valid = vmode == 1 ? 1'b0 : vmode == 2 ? (age == T - 1) : (($urandom % 100) < 25);
        bus.i_buttons = ($urandom % 4 == 0) ? m_btn : 8'($urandom);
        if (entog && $urandom % 40 == 0) bus.i_enable = ~bus.i_enable;
    endtask
    task automatic step_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
        drive();
    endtask
    initial begin
        int first_rd, second_rd, cnt, cnt2;
        bus.i_enable = 0;
        bus.i_poll_now = 0;
        bus.i_valid = 0;
        bus.i_buttons = 0;
        model_reset();
        #12;
        compare();
        // periodic reads: first at edge 20 after release, then every 20
        bus.i_enable = 1;
        vmode = 1;
        rst_n = 1;
        first_rd = -1;
        second_rd = -1;
        for (int n = 1; n <= 45; n++) begin
            step_cycle();
            if (bus.o_read_buttons) begin
                if (first_rd < 0) first_rd = n;
                else if (second_rd < 0) second_rd = n;
            end
        end
        check("first_rd", first_rd, P);
        check("period", second_rd - first_rd, P);
        // valid exactly on the watchdog expiry cycle
        vmode = 2;
        cnt = 0;
        cnt2 = 0;
        repeat (80) begin
            step_cycle();
            cnt += bus.o_timeout;
            cnt2 += bus.o_update;
        end
        check("exp_no_to", cnt, 0);
        check("exp_upd", cnt2 > 0, 1);
        // polling disabled: nothing periodic, manual poll reads next cycle
        bus.i_enable = 0;
        vmode = 0;
        cnt = 0;
        repeat (40) begin
            step_cycle();
            cnt += bus.o_read_buttons;
        end
        for (int n = 0; n < 30 && age != -2; n++) step_cycle();
        cnt = 0;
        repeat (30) begin
            step_cycle();
            cnt += bus.o_read_buttons;
        end
        check("dis_rd", cnt, 0);
        bus.i_poll_now = 1;
        step_cycle();
        check("poll_rd", bus.o_read_buttons, 1);
        // random mix with heavy manual polling to exercise the pending slot
        ppoll = 30;
        entog = 1;
        cnt = 0;
        repeat (3000) begin
            step_cycle();
            cnt += bus.o_overrun;
        end
        check("ovr_seen", cnt > 0, 1);
        // async reset mid-WAIT
        ppoll = 0;
        entog = 0;
        vmode = 1;
        bus.i_enable = 0;
        for (int n = 0; n < 40 && age < 0; n++) begin
            if (age == -2) bus.i_poll_now = 1;
            step_cycle();
        end
        check("in_wait", age >= 0, 1);
        #2;
        rst_n = 0;
        #1;
        check("rst_busy", bus.o_busy, 0);
        check("rst_rd", bus.o_read_buttons, 0);
        check("rst_btn", bus.o_buttons, 0);
        check("rst_pulses", {bus.o_pressed, bus.o_released, bus.o_update, bus.o_timeout, bus.o_overrun}, 0);
        model_reset();
        bus.i_poll_now = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (10) step_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
